// File: rtl/sram_responder_if.sv
// sram_responder_if: CPU-side SRAM bus bundle.
//   CE/OE/WE/UB/LB : active-low chip controls (master -> slave)
//   ADDR           : 20-bit word address       (master -> slave)
//   Data_write     : write data                (master -> slave)
//   Data_read      : registered read data      (slave -> master)
//   Data_oe        : read data being driven    (slave -> master)
//   R              : access-complete ready     (slave -> master)
interface sram_responder_if;
  logic        CE;
  logic        OE;
  logic        WE;
  logic        UB;
  logic        LB;
  logic [19:0] ADDR;
  logic [15:0] Data_write;
  logic [15:0] Data_read;
  logic        Data_oe;
  logic        R;

  modport master (
    output CE, OE, WE, UB, LB, ADDR, Data_write,
    input  Data_read, Data_oe, R
  );

  modport slave (
    input  CE, OE, WE, UB, LB, ADDR, Data_write,
    output Data_read, Data_oe, R
  );
endinterface

// File: rtl/sram_responder.sv
// sram_responder: memory-side model of the SLC-3 external SRAM.
// Services each request from an internal 2^ADDR_W x 16 array after WAIT
// wait states, then holds R high until the request is dropped.
//   Clk   : clock, rising edge
//   Reset : synchronous, active high (array contents are not cleared)
//   bus   : sram_responder_if.slave (controls, address, data, R, Data_oe)
module sram_responder #(
  parameter int ADDR_W = 10,
  parameter int WAIT   = 2
) (
  input  logic                  Clk,
  input  logic                  Reset,
  sram_responder_if.slave       bus
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

  localparam logic [3:0] WAIT_LD = 4'((WAIT > 0) ? WAIT - 1 : 0);

  state_t              r_state;
  logic [3:0]          r_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_oor;
  logic                r_wr;
  logic                r_ub;
  logic                r_lb;
  logic [15:0]         r_wdata;
  logic [15:0]         r_rdata;
  logic                r_R;
  logic                r_oe;
  logic [15:0]         r_mem [2**ADDR_W];

  logic                w_req;
  logic                w_acc;
  logic                w_direct;
  logic [ADDR_W-1:0]   w_a_addr;
  logic                w_a_oor;
  logic                w_a_wr;
  logic                w_a_ub;
  logic                w_a_lb;
  logic [15:0]         w_a_wdata;
  logic [15:0]         w_rd_word;
  logic [15:0]         w_rd_val;

  // WE low wins over OE low: a simultaneous assertion is a write.
  assign w_req = ~bus.CE & (~bus.OE | ~bus.WE);

  // With WAIT=0 the access happens on the capture edge itself, so it must
  // use the live inputs; otherwise it uses the values captured in IDLE.
  assign w_acc    = ((r_state == S_IDLE) && w_req && (WAIT == 0)) ||
                    ((r_state == S_WAIT) && (r_cnt == 4'd0));
  assign w_direct = (r_state == S_IDLE);

  assign w_a_addr  = w_direct ? bus.ADDR[ADDR_W-1:0]   : r_addr;
  assign w_a_oor   = w_direct ? (|bus.ADDR[19:ADDR_W]) : r_oor;
  assign w_a_wr    = w_direct ? ~bus.WE                : r_wr;
  assign w_a_ub    = w_direct ? bus.UB                 : r_ub;
  assign w_a_lb    = w_direct ? bus.LB                 : r_lb;
  assign w_a_wdata = w_direct ? bus.Data_write         : r_wdata;

  assign w_rd_word = r_mem[w_a_addr];
  assign w_rd_val  = w_a_oor ? 16'h0000 :
                     {(w_a_ub ? 8'h00 : w_rd_word[15:8]),
                      (w_a_lb ? 8'h00 : w_rd_word[7:0])};

  // Array has no reset; gating on Reset drops a write still pending.
  always_ff @(posedge Clk) begin
    if (!Reset && w_acc && w_a_wr && !w_a_oor) begin
      if (!w_a_ub) r_mem[w_a_addr][15:8] <= w_a_wdata[15:8];
      if (!w_a_lb) r_mem[w_a_addr][7:0]  <= w_a_wdata[7:0];
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= '0;
      r_oor   <= 1'b0;
      r_wr    <= 1'b0;
      r_ub    <= 1'b1;
      r_lb    <= 1'b1;
      r_wdata <= 16'h0000;
      r_rdata <= 16'h0000;
      r_R     <= 1'b0;
      r_oe    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_addr  <= bus.ADDR[ADDR_W-1:0];
            r_oor   <= |bus.ADDR[19:ADDR_W];
            r_wr    <= ~bus.WE;
            r_ub    <= bus.UB;
            r_lb    <= bus.LB;
            r_wdata <= bus.Data_write;
            if (WAIT != 0) begin
              r_cnt   <= WAIT_LD;
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
        end
        S_HOLD: begin
          if (!w_req) begin
            r_state <= S_IDLE;
            r_R     <= 1'b0;
            r_oe    <= 1'b0;
          end else begin
            r_oe <= ~r_wr & ~bus.OE & ~bus.CE;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // Access completion overrides the per-state next-state above.
      if (w_acc) begin
        if (!w_a_wr) r_rdata <= w_rd_val;
        r_R     <= 1'b1;
        r_oe    <= ~w_a_wr & ~bus.OE & ~bus.CE;
        r_state <= S_HOLD;
      end
    end
  end

  assign bus.Data_read = r_rdata;
  assign bus.Data_oe   = r_oe;
  assign bus.R         = r_R;

endmodule

// File: tb/tb_sram_responder.sv
module tb_sram_responder;

  localparam int WAIT   = 2;
  localparam int ADDR_W = 10;

  logic clk;
  logic rst;
  sram_responder_if bus();

  sram_responder #(.ADDR_W(ADDR_W), .WAIT(WAIT)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // op: 0 read, 1 write, 2 OE and WE both low (a write)
  typedef struct {
    int          op;
    logic        ub;
    logic        lb;
    logic [19:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rd;
    string       name;
  } vec_t;

  typedef struct {
    logic        is_rd;
    logic [15:0] rd;
    string       name;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] last_rd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_bus();
    bus.CE = 1'b1; bus.OE = 1'b1; bus.WE = 1'b1;
    bus.UB = 1'b1; bus.LB = 1'b1;
  endtask

  // Called at a negedge. Drives the request, scoreboards the expectation,
  // waits for R, checks latency/data, drops the request and checks R falls.
  task automatic do_access(input vec_t v);
    exp_t e;
    int   n;
    bus.CE = 1'b0;
    bus.OE = (v.op == 1) ? 1'b1 : 1'b0;
    bus.WE = (v.op == 0) ? 1'b1 : 1'b0;
    bus.UB = v.ub; bus.LB = v.lb;
    bus.ADDR = v.addr; bus.Data_write = v.wdata;
    sb_q.push_back('{is_rd: (v.op == 0), rd: v.exp_rd, name: v.name});
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.R && n < 20);
    e = sb_q.pop_front();
    chk({e.name, " latency"}, 32'(n), 32'(WAIT + 1));
    if (e.is_rd) begin
      chk({e.name, " rdata"}, 32'(bus.Data_read), 32'(e.rd));
      chk({e.name, " oe"}, 32'(bus.Data_oe), 32'd1);
      last_rd = e.rd;
    end else begin
      chk({e.name, " oe"}, 32'(bus.Data_oe), 32'd0);
      chk({e.name, " rdata held"}, 32'(bus.Data_read), 32'(last_rd));
    end
    idle_bus();
    @(negedge clk);
    chk({e.name, " R drop"}, 32'(bus.R), 32'd0);
    chk({e.name, " oe drop"}, 32'(bus.Data_oe), 32'd0);
  endtask

  vec_t vecs[$];

  initial begin
    vecs = '{
      '{1, 1'b0, 1'b0, 20'h00010, 16'hBEEF, 16'h0000, "wr_beef"},
      '{0, 1'b0, 1'b0, 20'h00010, 16'h0000, 16'hBEEF, "rd_beef"},
      '{1, 1'b1, 1'b0, 20'h00010, 16'h1234, 16'h0000, "wr_lb_only"},
      '{0, 1'b0, 1'b0, 20'h00010, 16'h0000, 16'hBE34, "rd_be34"},
      '{0, 1'b0, 1'b1, 20'h00010, 16'h0000, 16'hBE00, "rd_ub_only"},
      '{0, 1'b1, 1'b0, 20'h00010, 16'h0000, 16'h0034, "rd_lb_only"},
      '{1, 1'b0, 1'b0, 20'h00000, 16'hCAFE, 16'h0000, "wr_zero"},
      '{1, 1'b0, 1'b0, 20'h00400, 16'hAAAA, 16'h0000, "wr_oor"},
      '{0, 1'b0, 1'b0, 20'h00400, 16'h0000, 16'h0000, "rd_oor"},
      '{0, 1'b0, 1'b0, 20'h80000, 16'h0000, 16'h0000, "rd_oor_hi"},
      '{0, 1'b0, 1'b0, 20'h00000, 16'h0000, 16'hCAFE, "rd_zero_intact"},
      '{1, 1'b0, 1'b0, 20'h003FF, 16'h5A5A, 16'h0000, "wr_top"},
      '{0, 1'b1, 1'b1, 20'h003FF, 16'h0000, 16'h0000, "rd_no_lanes"},
      '{0, 1'b0, 1'b0, 20'h003FF, 16'h0000, 16'h5A5A, "rd_top"},
      '{2, 1'b0, 1'b0, 20'h00030, 16'h7777, 16'h0000, "both_is_wr"},
      '{1, 1'b1, 1'b1, 20'h00030, 16'hFFFF, 16'h0000, "wr_no_lanes"},
      '{0, 1'b0, 1'b0, 20'h00030, 16'h0000, 16'h7777, "rd_7777"},
      '{1, 1'b0, 1'b0, 20'h00020, 16'h1111, 16'h0000, "wr_1111"},
      '{0, 1'b0, 1'b0, 20'h00020, 16'h0000, 16'h1111, "rd_1111"}
    };

    idle_bus();
    bus.ADDR = 20'h0; bus.Data_write = 16'h0;
    last_rd = 16'h0000;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state held through 5 idle cycles.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("reset R", 32'(bus.R), 32'd0);
      chk("reset oe", 32'(bus.Data_oe), 32'd0);
      chk("reset rdata", 32'(bus.Data_read), 32'h0);
    end

    foreach (vecs[i]) do_access(vecs[i]);

    // Hold the read request 10 cycles past R while ADDR wanders.
    bus.CE = 1'b0; bus.OE = 1'b0; bus.WE = 1'b1;
    bus.UB = 1'b0; bus.LB = 1'b0; bus.ADDR = 20'h00010;
    repeat (WAIT + 1) @(negedge clk);
    chk("hold first R", 32'(bus.R), 32'd1);
    chk("hold first rdata", 32'(bus.Data_read), 32'hBE34);
    for (int i = 0; i < 10; i++) begin
      bus.ADDR = 20'(i * 3);
      @(negedge clk);
      chk("hold R", 32'(bus.R), 32'd1);
      chk("hold oe", 32'(bus.Data_oe), 32'd1);
      chk("hold rdata", 32'(bus.Data_read), 32'hBE34);
    end
    bus.CE = 1'b1;
    @(negedge clk);
    chk("hold release R", 32'(bus.R), 32'd0);
    chk("hold release rdata", 32'(bus.Data_read), 32'hBE34);
    idle_bus();
    @(negedge clk);

    // Reset one cycle into a pending write: write must be dropped.
    bus.CE = 1'b0; bus.OE = 1'b1; bus.WE = 1'b0;
    bus.UB = 1'b0; bus.LB = 1'b0;
    bus.ADDR = 20'h00020; bus.Data_write = 16'h5555;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle_bus();
    chk("rst wait rdata", 32'(bus.Data_read), 32'h0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rst wait R", 32'(bus.R), 32'd0);
    end
    last_rd = 16'h0000;
    do_access('{0, 1'b0, 1'b0, 20'h00020, 16'h0000, 16'h1111, "rd_after_rst"});

    chk("scoreboard empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
